fifo_rd_packer: RTL

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Reads FIFO words one per cycle and packs PACK of them into a wide output word,
// with a flush path that emits a partially filled word, zero-padded.
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         FIFO_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    output logic                         rd_en,
    input  logic                         flush,
    output logic [DATA_WIDTH*PACK-1:0]   word_out,
    output logic [3:0]                   word_bytes,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [15:0]                  words_sent
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [3:0] PACK_CNT = 4'(PACK);

    logic [1:0]                 state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       inflight_q, inflight_d;
    logic [DATA_WIDTH*PACK-1:0] pack_q, pack_d;
    logic [DATA_WIDTH*PACK-1:0] word_out_q, word_out_d;
    logic [3:0]                 word_bytes_q, word_bytes_d;
    logic                       word_valid_q, word_valid_d;
    logic [15:0]                words_sent_q, words_sent_d;

    logic       flush_pending;
    logic       flush_pending_d;
    logic       out_free;
    logic       xfer;
    logic       flush_ready;
    logic       move;
    logic       flush_done;
    logic [4:0] fill_lvl;

    // The FLUSH state doubles as the flush_pending flag.
    assign flush_pending = (state_q == ST_FLUSH);
    assign out_free      = !word_valid_q || word_ready;
    assign xfer          = word_valid_q && word_ready;
    assign flush_ready   = flush_pending && !inflight_q;
    assign move          = out_free && ((cnt_q == PACK_CNT) || (flush_ready && (cnt_q != 4'd0)));
    assign flush_done    = flush_ready && (move || (cnt_q == 4'd0));
    assign fill_lvl      = {1'b0, cnt_q} + {4'b0000, inflight_q};

    // Reserving a slot for the in-flight word keeps the pack register from overflowing.
    assign rd_en = rd_rst && !FIFO_empty && !flush_pending && (fill_lvl < 5'(PACK));

    always_comb begin
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        word_out_d   = word_out_q;
        word_bytes_d = word_bytes_q;
        word_valid_d = word_valid_q;
        words_sent_d = words_sent_q;
        inflight_d   = rd_en;

        if (inflight_q) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (cnt_q == 4'(i)) begin
                    pack_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
                end
            end
            cnt_d = cnt_q + 4'd1;
        end

        if (xfer) begin
            word_valid_d = 1'b0;
            words_sent_d = words_sent_q + 16'd1;
        end

        // A move never coincides with a landing: both full and flush moves imply no read in flight.
        if (move) begin
            word_out_d = '0;
            for (int unsigned i = 0; i < PACK; i++) begin
                if (4'(i) < cnt_q) begin
                    word_out_d[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            word_bytes_d = cnt_q;
            word_valid_d = 1'b1;
            pack_d       = '0;
            cnt_d        = '0;
        end
    end

    always_comb begin
        flush_pending_d = flush_pending ? !flush_done : flush;
        if (flush_pending_d) begin
            state_d = ST_FLUSH;
        end else if (cnt_d == 4'd0) begin
            state_d = ST_IDLE;
        end else if (cnt_d == PACK_CNT) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            pack_q       <= '0;
            word_out_q   <= '0;
            word_bytes_q <= '0;
            word_valid_q <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
            pack_q       <= pack_d;
            word_out_q   <= word_out_d;
            word_bytes_q <= word_bytes_d;
            word_valid_q <= word_valid_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_bytes = word_bytes_q;
    assign word_valid = word_valid_q;
    assign words_sent = words_sent_q;

endmodule
